// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the hazard unit: register index and forwarding-select encodings.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    localparam regbits_t REG_ZERO = 5'd0;

    // A pipeline write hits a source only if it is enabled and never for r0.
    function automatic logic reg_hit(input logic wen, input regbits_t dst, input regbits_t src);
        return wen && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Output bundle of the hazard unit: forwarding selects, stall controls and stall counter.
interface hazard_unit_if;
    import cpu_types_pkg::*;

    fwd_sel_t    forwardA;
    fwd_sel_t    forwardB;
    fwd_sel_t    fwd_store;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_flush;
    logic [31:0] stall_cnt;

    modport hu (output forwardA, forwardB, fwd_store, pc_en, ifid_en, idex_flush, stall_cnt);
    modport tb (input  forwardA, forwardB, fwd_store, pc_en, ifid_en, idex_flush, stall_cnt);

endinterface

// File: rtl/fwd_sel.sv
// Forwarding source select for one ID/EX operand; EX/MEM result wins over MEM/WB.
module fwd_sel
    import cpu_types_pkg::*;
(
    input  logic [4:0] src,
    input  logic       exmem_wen,
    input  logic [4:0] exmem_dst,
    input  logic       mem_wen,
    input  logic [4:0] mem_dst,
    output logic [1:0] sel
);

    // Priority select: the younger producer in EX/MEM holds the newest value.
    always_comb begin
        sel = FWD_NONE;
        if (reg_hit(exmem_wen, exmem_dst, src)) begin
            sel = FWD_MEM;
        end else if (reg_hit(mem_wen, mem_dst, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding plus single-cycle load-use stall.
// Optional stall counter enabled by defining HAZARD_PERF_EN.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic [4:0] idex_rs,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       MemRead,
    input  logic [4:0] stall_rt,
    input  logic       idex_MemWrite,
    input  logic       exmem_RegWEN,
    input  logic [4:0] exmem_RegDst,
    input  logic       mem_RegWEN,
    input  logic [4:0] mem_RegDst,
    hazard_unit_if.hu  huif
);

    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       load_use_s;
    logic       stall_s;
    logic       stalled_d;
    logic       stalled_q;

    fwd_sel u_fwd_rs (
        .src       (idex_rs),
        .exmem_wen (exmem_RegWEN),
        .exmem_dst (exmem_RegDst),
        .mem_wen   (mem_RegWEN),
        .mem_dst   (mem_RegDst),
        .sel       (fwd_a_s)
    );

    fwd_sel u_fwd_rt (
        .src       (idex_rt),
        .exmem_wen (exmem_RegWEN),
        .exmem_dst (exmem_RegDst),
        .mem_wen   (mem_RegWEN),
        .mem_dst   (mem_RegDst),
        .sel       (fwd_b_s)
    );

    // Load-use detection; the stalled flop suppresses a second back-to-back stall.
    always_comb begin
        load_use_s = MemRead && (stall_rt != REG_ZERO) &&
                     ((stall_rt == ifid_rs) || (stall_rt == ifid_rt));
        stall_s    = load_use_s && !stalled_q;
        stalled_d  = stall_s;
    end

    // Forwarding selects and pipeline controls, all same-cycle.
    always_comb begin
        huif.forwardA   = fwd_sel_t'(fwd_a_s);
        huif.forwardB   = fwd_sel_t'(fwd_b_s);
        if (idex_MemWrite) begin
            huif.fwd_store = fwd_sel_t'(fwd_b_s);
        end else begin
            huif.fwd_store = FWD_NONE;
        end
        huif.pc_en      = !stall_s;
        huif.ifid_en    = !stall_s;
        huif.idex_flush = stall_s;
    end

    // Remember whether the previous cycle stalled.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            stalled_q <= 1'b0;
        end else begin
            stalled_q <= stalled_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;

    // Free-running stall counter; wraps naturally at 32 bits.
    always_comb begin
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter state.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign huif.stall_cnt = stall_cnt_q;
`else
    assign huif.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table plus stall/reset sequences.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    typedef struct {
        logic [4:0] idex_rs, idex_rt, ifid_rs, ifid_rt;
        logic       mem_read;
        logic [4:0] stall_rt;
        logic       idex_mw;
        logic       ex_wen;
        logic [4:0] ex_dst;
        logic       mem_wen;
        logic [4:0] mem_dst;
        logic [1:0] fa, fb, fs;
        logic       stall;
    } vec_t;

    typedef struct {
        logic [1:0]  fa, fb, fs;
        logic        stall;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRST = 1'b1;
    logic [4:0] idex_rs = 5'd0, idex_rt = 5'd0, ifid_rs = 5'd0, ifid_rt = 5'd0;
    logic       MemRead = 1'b0;
    logic [4:0] stall_rt = 5'd0;
    logic       idex_MemWrite = 1'b0;
    logic       exmem_RegWEN = 1'b0;
    logic [4:0] exmem_RegDst = 5'd0;
    logic       mem_RegWEN = 1'b0;
    logic [4:0] mem_RegDst = 5'd0;

    hazard_unit_if huif ();

    hazard_unit dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .idex_rs       (idex_rs),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .MemRead       (MemRead),
        .stall_rt      (stall_rt),
        .idex_MemWrite (idex_MemWrite),
        .exmem_RegWEN  (exmem_RegWEN),
        .exmem_RegDst  (exmem_RegDst),
        .mem_RegWEN    (mem_RegWEN),
        .mem_RegDst    (mem_RegDst),
        .huif          (huif)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;
    exp_t        sb_q[$];
    vec_t        tbl[12];

    function automatic vec_t mkv(input logic [4:0] irs, irt, frs, frt,
                                 input logic mr, input logic [4:0] srt, input logic mw,
                                 input logic ew, input logic [4:0] ed,
                                 input logic mwn, input logic [4:0] md,
                                 input logic [1:0] fa, fb, fs, input logic st);
        vec_t v;
        v.idex_rs = irs; v.idex_rt = irt; v.ifid_rs = frs; v.ifid_rt = frt;
        v.mem_read = mr; v.stall_rt = srt; v.idex_mw = mw;
        v.ex_wen = ew; v.ex_dst = ed; v.mem_wen = mwn; v.mem_dst = md;
        v.fa = fa; v.fb = fb; v.fs = fs; v.stall = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        idex_rs = v.idex_rs; idex_rt = v.idex_rt; ifid_rs = v.ifid_rs; ifid_rt = v.ifid_rt;
        MemRead = v.mem_read; stall_rt = v.stall_rt; idex_MemWrite = v.idex_mw;
        exmem_RegWEN = v.ex_wen; exmem_RegDst = v.ex_dst;
        mem_RegWEN = v.mem_wen; mem_RegDst = v.mem_dst;
    endtask

    task automatic push_exp(input logic [1:0] fa, fb, fs, input logic st, input string tag);
        exp_t e;
        e.fa = fa; e.fb = fb; e.fs = fs; e.stall = st; e.cnt = exp_cnt; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".forwardA"},   32'(huif.forwardA),   32'(e.fa));
            chk({e.tag, ".forwardB"},   32'(huif.forwardB),   32'(e.fb));
            chk({e.tag, ".fwd_store"},  32'(huif.fwd_store),  32'(e.fs));
            chk({e.tag, ".pc_en"},      32'(huif.pc_en),      32'(!e.stall));
            chk({e.tag, ".ifid_en"},    32'(huif.ifid_en),    32'(!e.stall));
            chk({e.tag, ".idex_flush"}, 32'(huif.idex_flush), 32'(e.stall));
            chk({e.tag, ".stall_cnt"},  huif.stall_cnt,       e.cnt);
        end
    endtask

    // Counter advances on the edge that closes a stalled cycle, only outside reset.
    task automatic count_edge(input logic st);
`ifdef HAZARD_PERF_EN
        if (st && !nRST) exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge CLK);
        drive(v);
        push_exp(v.fa, v.fb, v.fs, v.stall, tag);
        #1;
        pop_check();
        count_edge(v.stall);
    endtask

    vec_t idle_v, lu_v;

    initial begin
        idle_v = mkv(5'd0,5'd0,5'd0,5'd0, 1'b0,5'd0,1'b0, 1'b0,5'd0, 1'b0,5'd0, 2'b00,2'b00,2'b00,1'b0);
        lu_v   = mkv(5'd0,5'd0,5'd1,5'd0, 1'b1,5'd1,1'b0, 1'b0,5'd0, 1'b0,5'd0, 2'b00,2'b00,2'b00,1'b1);

        tbl[0]  = idle_v;
        tbl[1]  = mkv(5'd1,5'd1,5'd0,5'd0, 1'b0,5'd0,1'b0, 1'b0,5'd0, 1'b1,5'd1, 2'b01,2'b01,2'b00,1'b0);
        tbl[2]  = mkv(5'd1,5'd1,5'd0,5'd0, 1'b0,5'd0,1'b0, 1'b1,5'd1, 1'b1,5'd1, 2'b10,2'b10,2'b00,1'b0);
        tbl[3]  = mkv(5'd1,5'd1,5'd0,5'd0, 1'b0,5'd0,1'b1, 1'b1,5'd1, 1'b1,5'd1, 2'b10,2'b10,2'b10,1'b0);
        tbl[4]  = mkv(5'd0,5'd0,5'd0,5'd0, 1'b1,5'd0,1'b0, 1'b1,5'd0, 1'b0,5'd0, 2'b00,2'b00,2'b00,1'b0);
        tbl[5]  = mkv(5'd3,5'd4,5'd0,5'd0, 1'b0,5'd0,1'b1, 1'b1,5'd3, 1'b1,5'd4, 2'b10,2'b01,2'b01,1'b0);
        tbl[6]  = mkv(5'd3,5'd7,5'd0,5'd0, 1'b0,5'd0,1'b0, 1'b0,5'd3, 1'b1,5'd7, 2'b00,2'b01,2'b00,1'b0);
        tbl[7]  = mkv(5'd5,5'd0,5'd0,5'd9, 1'b1,5'd9,1'b0, 1'b1,5'd5, 1'b0,5'd0, 2'b10,2'b00,2'b00,1'b1);
        tbl[8]  = mkv(5'd0,5'd0,5'd0,5'd0, 1'b0,5'd0,1'b0, 1'b0,5'd0, 1'b1,5'd0, 2'b00,2'b00,2'b00,1'b0);
        tbl[9]  = mkv(5'd8,5'd6,5'd2,5'd0, 1'b0,5'd2,1'b1, 1'b1,5'd6, 1'b1,5'd8, 2'b01,2'b10,2'b10,1'b0);
        tbl[10] = mkv(5'd0,5'd0,5'd6,5'd0, 1'b1,5'd6,1'b0, 1'b0,5'd0, 1'b0,5'd0, 2'b00,2'b00,2'b00,1'b1);
        tbl[11] = idle_v;

        // Reset state with all inputs low.
        drive(idle_v);
        @(negedge CLK);
        push_exp(2'b00, 2'b00, 2'b00, 1'b0, "reset");
        #1;
        pop_check();
        @(negedge CLK);
        nRST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Persistent load-use: stalls alternate, never back to back.
        for (int i = 0; i < 4; i++) begin
            vec_t v;
            v = lu_v;
            v.stall = (i % 2 == 0);
            step(v, $sformatf("persist%0d", i));
        end
        step(idle_v, "idle_after_persist");

        // Reset asserted mid-stall clears the stall history at once.
        step(lu_v, "rst_seq_stall");
        begin
            vec_t v;
            v = lu_v;
            v.stall = 1'b0;
            step(v, "rst_seq_held");
        end
        #2;
        nRST = 1'b1;
        exp_cnt = 32'd0;
        push_exp(2'b00, 2'b00, 2'b00, 1'b1, "rst_async");
        #1;
        pop_check();
        step(lu_v, "rst_during");
        @(negedge CLK);
        nRST = 1'b0;
        drive(idle_v);
        push_exp(2'b00, 2'b00, 2'b00, 1'b0, "rst_release");
        #1;
        pop_check();
        count_edge(1'b0);
        step(lu_v, "post_rst_stall");

        if (sb_q.size() != 0) chk("scoreboard_leftover", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 nRST  input  1  asynchronous reset, asserted when 1 (active-high despite the codebase name).
REQ-004 idex_rs, idex_rt  input  5 (regbits_t)  source registers of the instruction in ID/EX.
REQ-005 ifid_rs, ifid_rt  input  5  source registers of the instruction in IF/ID.
REQ-006 MemRead  input  1  ID/EX instruction is a load.
REQ-007 stall_rt  input  5  destination register of the ID/EX load.
REQ-008 idex_MemWrite  input  1  ID/EX instruction is a store.
REQ-009 exmem_RegWEN, exmem_RegDst  input  1, 5  EX/MEM write enable and destination register.
REQ-010 mem_RegWEN, mem_RegDst  input  1, 5  MEM/WB write enable and destination register.
REQ-011 huif  modport hazard_unit_if.hu: outputs forwardA, forwardB, fwd_store (fwd_sel_t, 2 bits each), pc_en, ifid_en, idex_flush (1 bit each), stall_cnt (32 bits).

Function
REQ-012 fwd_sel_t encoding SHALL be: FWD_NONE=00 (register file), FWD_WB=01 (MEM/WB), FWD_MEM=10 (EX/MEM); 11 is never driven.
REQ-013 forwardA SHALL be FWD_MEM when exmem_RegWEN=1, exmem_RegDst!=0 and exmem_RegDst==idex_rs.
REQ-014 Otherwise forwardA SHALL be FWD_WB when mem_RegWEN=1, mem_RegDst!=0 and mem_RegDst==idex_rs; otherwise FWD_NONE.
REQ-015 forwardB SHALL apply the rules of REQ-013/014 with idex_rt in place of idex_rs.
REQ-016 fwd_store SHALL equal forwardB when idex_MemWrite=1 and FWD_NONE otherwise.
REQ-017 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-018 load_use SHALL be 1 when MemRead=1, stall_rt!=0 and (stall_rt==ifid_rs or stall_rt==ifid_rt).
REQ-019 stall SHALL equal load_use AND NOT stalled_q, where stalled_q is a flop holding the previous cycle's stall.
REQ-020 While stall=1: pc_en=0, ifid_en=0, idex_flush=1; otherwise pc_en=1, ifid_en=1, idex_flush=0.
REQ-021 Consecutive stalls SHALL NOT occur: after one stall cycle, stall is 0 for at least one cycle even if load_use persists.
REQ-022 Forwarding outputs SHALL be combinational and valid in the same cycle as their inputs; stall has zero-cycle latency from its inputs.
REQ-023 Forwarding and stalling SHALL be independent: both may be active in the same cycle.

Reset
REQ-024 While nRST=1: stalled_q=0 and stall_cnt=0, so pc_en=1, ifid_en=1, idex_flush=0 unless load_use=1.
REQ-025 Forwarding outputs SHALL not depend on reset.
REQ-026 Reset asserted mid-stall SHALL clear stalled_q immediately (asynchronously).

Configuration
REQ-027 Macro HAZARD_PERF_EN: when defined, stall_cnt increments by 1 on every rising edge with stall=1 and wraps from 0xFFFFFFFF to 0.
REQ-028 When HAZARD_PERF_EN is undefined, stall_cnt SHALL be tied to 0 and no counter flops are synthesized.

Structure
REQ-029 regbits_t (5 bits) and fwd_sel_t SHALL reside in cpu_types_pkg.
REQ-030 hazard_unit_if SHALL declare all huif signals and the hu and tb modports.
REQ-031 Forward selection SHALL be one sub-module, fwd_sel, instantiated twice (rs, rt).

Verification
REQ-032 All inputs 0 -> forwardA=forwardB=00, pc_en=1, ifid_en=1, idex_flush=0.
REQ-033 mem_RegWEN=1, mem_RegDst=1, idex_rs=idex_rt=1 -> forwardA=forwardB=01, fwd_store=00.
REQ-034 Additionally exmem_RegWEN=1, exmem_RegDst=1 -> forwardA=forwardB=10 (EX/MEM priority); with idex_MemWrite=1 -> fwd_store=10.
REQ-035 MemRead=1, stall_rt=1, ifid_rs=1 -> first cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle released; with HAZARD_PERF_EN, stall_cnt=1.
REQ-036 exmem_RegDst=0, exmem_RegWEN=1, idex_rs=0, and MemRead=1 with stall_rt=0 -> no forwarding, no stall.
REQ-037 nRST=1 asserted during a stall -> stalled_q=0 and stall_cnt=0 immediately; outputs follow REQ-024.
